pipe_trace_capture: RTL
=======================

// Module: pipe_trace_capture
// PURPOSE
//  Synthesisable successor to the per-tick PC printout. Samples the PC and valid bit
//  of NSTAGE pipeline stages every cycle into a circular trace RAM.
//  Freezes after a configurable trigger plus a post-trigger window.
//  Streams the captured window out oldest-first over a valid/ready port for the debug
//  UART or a bench. Sits beside the diad core and taps its stage PC registers.
// PARAMETERS
//  NSTAGE  8   number of pipeline stages traced (IA..FINAL)
//  PC_W    24  width of each stage PC
//  DEPTH   64  trace entries; power of two, >=4
//  TICK_W  16  width of free-running cycle stamp stored per entry
// PORTS
//  clk         in   1                 core clock
//  rst         in   1                 synchronous, active-high reset
//  stage_pc    in   NSTAGE*PC_W       stage s PC at [s*PC_W +: PC_W]; s=0 is IA
//  stage_vld   in   NSTAGE            per-stage valid
//  arm         in   1                 pulse: clear and start capture (any state)
//  trig_mode   in   2                 0 immediate, 1 PC match, 2 external, 3 never (free-run)
//  trig_stage  in   $clog2(NSTAGE)    stage compared in PC-match mode
//  trig_pc     in   PC_W              match value
//  ext_trig    in   1                 external trigger, mode 2
//  post_cnt    in   $clog2(DEPTH)     samples after trigger sample; values >DEPTH-1 impossible by width
//  busy        out  1                 state is PRE or POST
//  triggered   out  1                 trigger seen since last arm
//  rd_valid    out  1                 rd_data holds an entry
//  rd_ready    in   1                 consumer accepts entry
//  rd_data     out  TICK_W+NSTAGE*(PC_W+1)   {tick, stage_vld, stage_pc}
//  rd_last     out  1                 qualifies final entry of window
// BEHAVIOUR
//  Reset: state IDLE; busy, triggered, rd_valid, rd_last = 0; rd_data = 0.
//  Reset: wptr = 0, fill = 0, tick = 0. Reset mid-capture or mid-readout discards everything.
//  tick: free-running, +1 every cycle, wraps 2^TICK_W-1 -> 0. Not reset by arm.
//  States: IDLE -> (arm) PRE -> (trigger) POST -> (post done) READ -> (last accepted) IDLE.
//  PRE: every cycle writes {tick, stage_vld, stage_pc} at wptr; wptr+1 mod DEPTH.
//  PRE: fill saturates at DEPTH.
//  Trigger evaluation is in PRE only, on the current-cycle inputs:
//   mode 0 -> first PRE cycle.
//   mode 1 -> stage_vld[trig_stage] && stage_pc[trig_stage] == trig_pc.
//   mode 2 -> ext_trig. mode 3 -> never; capture runs until arm.
//  Trigger cycle: sample is written; triggered <= 1. If post_cnt == 0, next state is READ.
//  Otherwise next state is POST with pcnt = post_cnt.
//  POST: writes as in PRE, pcnt-1 per write. The write that brings pcnt to 0 is the
//  last write; the next state is READ.
//  Window = min(fill, DEPTH) entries ending at the last write.
//  Oldest entry is at wptr if fill == DEPTH, else at 0.
//  READ: RAM read is synchronous (1 cycle). First rd_valid is asserted 2 cycles after
//  entering READ.
//  READ: rd_data and rd_last are held stable while rd_valid && !rd_ready.
//  READ: on rd_valid && rd_ready the next entry is presented in the following cycle
//  (prefetch, no bubble).
//  rd_last = 1 with the final entry. Accepting it -> IDLE, rd_valid 0. triggered stays 1
//  until the next arm.
//  arm in any state (incl. READ mid-stream) -> PRE next cycle.
//  arm also sets fill = 0, wptr = 0, triggered = 0, rd_valid = 0. arm has priority over
//  trigger and readout.
//  Trigger input while in POST/READ/IDLE is ignored. No RAM writes in IDLE or READ.
//  trig_*/post_cnt are sampled when used; they must be held stable from arm to trigger.
// STRUCTURE
//  trace_defs.vh: state encodings (IDLE, PRE, POST, READ), TRIG_* mode constants, and
//  ENTRY_W = TICK_W+NSTAGE*(PC_W+1).
//  Sub-module trace_ram: DEPTH x ENTRY_W simple dual-port.
//   1 write port, 1 registered read port, no reset on storage.
//  Top-level holds the FSM, pointers, fill/pcnt counters, trigger compare, and the read
//  prefetch/skid register.
// TESTING
//  Use NSTAGE=8, PC_W=24, DEPTH=8; stage_pc[s] = cycle*4+s.
//  T1 immediate: arm, mode 0, post_cnt 3
//   -> exactly 4 entries, ticks consecutive, rd_last on the 4th, then IDLE.
//  T2 PC match with wrap: mode 1, stage 2, trig_pc = 0x000052, post_cnt 2, 20 cycles of
//  pre-history -> 8 entries.
//   Oldest tick = trigger tick-5. Trigger entry is the 6th.
//  T3 backpressure: T2 with rd_ready toggling 1,0,0,1 -> rd_data and rd_last stable while
//  stalled, no entry lost or duplicated.
//  T4 external: mode 2, ext_trig pulse during POST is ignored -> window length post_cnt+1
//  when fewer than 8 written.
//  T5 abort: arm during READ after 3 accepts -> rd_valid 0 next cycle, busy 1, triggered 0.
//   New capture then reads out correctly.
//  T6 reset: rst in POST -> all outputs 0 next cycle. tick restarts at 0. Mode 3 never
//  leaves PRE.

Source files
------------

// File: rtl/pipe_trace_capture_pkg.sv
// Shared definitions for the pipeline trace capture block.
//   state_t   : capture/readout FSM states (IDLE, PRE, POST, READ)
//   TRIG_*    : trigger mode encodings carried on trig_mode
//   entry_w() : width of one trace entry {tick, stage_vld, stage_pc}
package pipe_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_READ = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM   = 2'd0;  // first PRE cycle
  localparam logic [1:0] TRIG_PC    = 2'd1;  // selected stage valid and PC equal
  localparam logic [1:0] TRIG_EXT   = 2'd2;  // external trigger pin
  localparam logic [1:0] TRIG_NEVER = 2'd3;  // free-run until the next arm

  function automatic int entry_w(input int nstage, input int pc_w, input int tick_w);
    return tick_w + nstage * (pc_w + 1);
  endfunction

endpackage

// File: rtl/pipe_trace_capture_ram.sv
// Trace storage: DEPTH x W simple dual-port RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata written at the clock edge
//   re    : read enable, rdata <= mem[raddr] at the clock edge
//   rdata : registered read data; holds its value while re is low
// Storage and the read register carry no reset.
module pipe_trace_capture_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 216,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_capture.sv
// Pipeline trace capture. Samples every stage PC and valid bit each cycle into a
// circular trace RAM, freezes after a trigger plus a post-trigger window, then
// streams the window out oldest-first.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   stage_pc/stage_vld : tapped stage PCs (stage s at [s*PC_W +: PC_W]) and valids
//   arm                : clear and restart capture from any state
//   trig_mode/trig_stage/trig_pc/ext_trig : trigger selection
//   post_cnt           : samples captured after the trigger sample
//   busy, triggered    : status
//   rd_valid/rd_ready/rd_data/rd_last : readout stream, entry = {tick, vld, pc}
//   dbg_state          : current FSM state
// Readout handshake: an entry transfers on a cycle where rd_valid && rd_ready;
// while rd_valid && !rd_ready, rd_data and rd_last are held unchanged, and rd_valid
// never drops without a transfer (except on arm or rst).
module pipe_trace_capture
  import pipe_trace_capture_pkg::*;
#(
  parameter int NSTAGE = 8,
  parameter int PC_W   = 24,
  parameter int DEPTH  = 64,
  parameter int TICK_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(NSTAGE),
  localparam int EW    = entry_w(NSTAGE, PC_W, TICK_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSTAGE*PC_W-1:0] stage_pc,
  input  logic [NSTAGE-1:0]      stage_vld,
  input  logic                   arm,
  input  logic [1:0]             trig_mode,
  input  logic [SW-1:0]          trig_stage,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic                   ext_trig,
  input  logic [AW-1:0]          post_cnt,
  output logic                   busy,
  output logic                   triggered,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [EW-1:0]          rd_data,
  output logic                   rd_last,
  output logic [1:0]             dbg_state
);

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_F = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  state_t state_q, state_d;

  logic [TICK_W-1:0] tick_q;
  logic [AW-1:0]     wptr_q, pcnt_q, rd_addr_q;
  logic [AW:0]       fill_q, rd_remain_q;
  logic              pre_first_q, triggered_q;
  // s1 is the RAM read register acting as a prefetch stage in front of rd_data.
  logic              s1_v_q, s1_last_q;
  logic [EW-1:0]     ram_rdata, rd_data_q;
  logic              rd_valid_q, rd_last_q;

  logic              cap, we, trig_hit, last_write, out_free, move, re;
  logic [PC_W-1:0]   sel_pc;
  logic [AW-1:0]     wptr_inc;
  logic [AW:0]       fill_inc;

  assign cap      = (state_q == ST_PRE) || (state_q == ST_POST);
  assign we       = cap && !arm;
  assign wptr_inc = wptr_q + ONE_A;
  assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + ONE_F;

  always_comb begin
    trig_hit = 1'b0;
    sel_pc   = stage_pc[trig_stage*PC_W +: PC_W];
    case (trig_mode)
      TRIG_IMM:   trig_hit = pre_first_q;
      TRIG_PC:    trig_hit = stage_vld[trig_stage] && (sel_pc == trig_pc);
      TRIG_EXT:   trig_hit = ext_trig;
      TRIG_NEVER: trig_hit = 1'b0;
    endcase
  end

  assign last_write = ((state_q == ST_PRE) && trig_hit && (post_cnt == '0)) ||
                      ((state_q == ST_POST) && (pcnt_q == ONE_A));

  // Refill the output register whenever it is empty or being consumed; issue the
  // next RAM read whenever the prefetch stage is empty or moving forward.
  assign out_free = !rd_valid_q || rd_ready;
  assign move     = s1_v_q && out_free;
  assign re       = (state_q == ST_READ) && (rd_remain_q != '0) && (!s1_v_q || move);

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_PRE;
    end else begin
      case (state_q)
        ST_PRE:  if (trig_hit) state_d = (post_cnt == '0) ? ST_READ : ST_POST;
        ST_POST: if (pcnt_q == ONE_A) state_d = ST_READ;
        ST_READ: if (rd_valid_q && rd_ready && rd_last_q) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      pcnt_q      <= '0;
      rd_addr_q   <= '0;
      rd_remain_q <= '0;
      pre_first_q <= 1'b0;
      triggered_q <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
      if (arm) begin
        wptr_q      <= '0;
        fill_q      <= '0;
        pcnt_q      <= '0;
        rd_remain_q <= '0;
        pre_first_q <= 1'b1;
        triggered_q <= 1'b0;
        s1_v_q      <= 1'b0;
        rd_valid_q  <= 1'b0;
        rd_last_q   <= 1'b0;
      end else begin
        if (state_q == ST_PRE) pre_first_q <= 1'b0;
        if (we) begin
          wptr_q <= wptr_inc;
          fill_q <= fill_inc;
        end
        if ((state_q == ST_PRE) && trig_hit) begin
          triggered_q <= 1'b1;
          pcnt_q      <= post_cnt;
        end
        if (state_q == ST_POST) pcnt_q <= pcnt_q - ONE_A;
        // Window ends at this write; oldest entry is the next slot once the RAM has wrapped.
        if (last_write) begin
          rd_addr_q   <= (fill_inc == FULL) ? wptr_inc : '0;
          rd_remain_q <= fill_inc;
        end
        if (re) begin
          rd_addr_q   <= rd_addr_q + ONE_A;
          rd_remain_q <= rd_remain_q - ONE_F;
          s1_v_q      <= 1'b1;
          s1_last_q   <= (rd_remain_q == ONE_F);
        end else if (move) begin
          s1_v_q <= 1'b0;
        end
        if (move) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= ram_rdata;
          rd_last_q  <= s1_last_q;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
        end
      end
    end
  end

  pipe_trace_capture_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata ({tick_q, stage_vld, stage_pc}),
    .re    (re),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign busy      = cap;
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign dbg_state = state_q;

endmodule
